calc_sequencer: RTL and testbench

Keypad-driven controller that sequences the encoder → register bank → ALU datapath.
- Consumes decoded key events and writes operand digits into the register bank.
- Latches the selected ALU operation, then on ENTER drives the read addresses and op and captures the ALU result.
- Sits between the keypad encoder and the REG/ALU instances in the top level.
- Replaces the direct switch-driven address/op/enable wiring.

---
 rtl/calc_seq_pkg.sv | 37 +++
 rtl/calc_seq_if.sv | 41 ++++
 rtl/seq_timeout_ctr.sv | 25 ++
 rtl/calc_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_seq_pkg.sv
// calc_sequencer shared definitions: state encoding,
// key codes and ALU op encodings.
package calc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GOT_A  = 3'd1,
    S_WAIT_B = 3'd2,
    S_GOT_B  = 3'd3,
    S_EXEC   = 3'd4,
    S_CAPT   = 3'd5,
    S_SHOW   = 3'd6
  } state_t;

  localparam logic [3:0] KEY_DIG_MIN = 4'h0;
  localparam logic [3:0] KEY_DIG_MAX = 4'h9;
  localparam logic [3:0] KEY_ADD     = 4'hA;
  localparam logic [3:0] KEY_SUB     = 4'hB;
  localparam logic [3:0] KEY_AND     = 4'hC;
  localparam logic [3:0] KEY_OR      = 4'hD;
  localparam logic [3:0] KEY_ENTER   = 4'hE;
  localparam logic [3:0] KEY_CLEAR   = 4'hF;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  function automatic logic [1:0] key_to_op(
    input logic [3:0] k
  );
    logic [3:0] d;
    d = k - KEY_ADD;
    return d[1:0];
  endfunction

endpackage

// File: rtl/calc_seq_if.sv
// Key-event / register-bank / ALU bundle around
// calc_sequencer.
interface calc_seq_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic [1:0] alu_op;
  logic       chain_sel;
  logic [7:0] result_q;
  logic       zero_q;
  logic       result_valid;
  logic       err;
  logic       busy;
  logic [2:0] state_o;

  modport slave (
    input  key_valid, key_code,
    input  alu_result, alu_zero,
    output wr_en, wr_addr, wr_data,
    output rd_addr_a, rd_addr_b, alu_op,
    output chain_sel, result_q, zero_q,
    output result_valid, err, busy,
    output state_o
  );

  modport master (
    output key_valid, key_code,
    output alu_result, alu_zero,
    input  wr_en, wr_addr, wr_data,
    input  rd_addr_a, rd_addr_b, alu_op,
    input  chain_sel, result_q, zero_q,
    input  result_valid, err, busy,
    input  state_o
  );
endinterface

// File: rtl/seq_timeout_ctr.sv
// Saturating 24-bit idle counter with a terminal
// flag at TIMEOUT_CYCLES-1.
module seq_timeout_ctr #(
  parameter logic [23:0] TIMEOUT_CYCLES =
    24'd10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);
  logic [23:0] r_cnt;

  // count enabled idle cycles, hold at all-ones
  always_ff @(posedge clk) begin
    if (reset || i_clr)
      r_cnt <= '0;
    else if (i_en && (r_cnt != '1))
      r_cnt <= r_cnt + 24'd1;
  end

  assign o_term =
    (r_cnt == (TIMEOUT_CYCLES - 24'd1));
endmodule

// File: rtl/calc_sequencer.sv
// Keypad sequencer for the encoder/REG/ALU datapath.
// Build option: CALC_SEQ_CHAIN_EN (op key in SHOW chains).
module calc_sequencer
  import calc_seq_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES =
    24'd10_000_000,
  parameter logic [1:0] A_ADDR = 2'd0,
  parameter logic [1:0] B_ADDR = 2'd1
) (
  input logic       clk,
  input logic       reset,
  calc_seq_if.slave bus
);
  state_t     r_state, w_state_nx;
  logic       r_wr_en, w_wr_en;
  logic [1:0] r_wr_addr, w_wr_addr;
  logic [3:0] r_wr_data, w_wr_data;
  logic [1:0] r_rd_a, w_rd_a;
  logic [1:0] r_rd_b, w_rd_b;
  logic [1:0] r_alu_op, w_alu_op;
  logic       r_chain, w_chain;
  logic [7:0] r_result, w_result;
  logic       r_zero, w_zero;
  logic       r_rv, w_rv;
  logic       r_err, w_err;
  logic       r_busy;
  logic       r_settle, w_settle;

  logic w_kv, w_dig, w_op, w_ent, w_clr;
  logic w_entry, w_term, w_timeout;
  logic [3:0] w_key;

  assign w_kv  = bus.key_valid;
  assign w_key = bus.key_code;
  assign w_dig = (w_key <= KEY_DIG_MAX);
  assign w_op  = (w_key >= KEY_ADD) &&
                 (w_key <= KEY_OR);
  assign w_ent = (w_key == KEY_ENTER);
  assign w_clr = (w_key == KEY_CLEAR);

  assign w_entry = (r_state == S_GOT_A)  ||
                   (r_state == S_WAIT_B) ||
                   (r_state == S_GOT_B);

  seq_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_to (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_kv | ~w_entry),
    .i_en  (w_entry & ~w_kv),
    .o_term(w_term)
  );

  assign w_timeout = w_entry & ~w_kv & w_term;

  // next state and next registered outputs
  always_comb begin
    w_state_nx = r_state;
    w_wr_en    = 1'b0;
    w_wr_addr  = r_wr_addr;
    w_wr_data  = r_wr_data;
    w_rd_a     = r_rd_a;
    w_rd_b     = r_rd_b;
    w_alu_op   = r_alu_op;
    w_chain    = r_chain;
    w_result   = r_result;
    w_zero     = r_zero;
    w_rv       = 1'b0;
    w_err      = 1'b0;
    w_settle   = 1'b0;
    if (w_kv && w_clr) begin
      w_state_nx = S_IDLE;
      w_result   = 8'h00;
      w_zero     = 1'b0;
      w_chain    = 1'b0;
    end else if (w_timeout) begin
      w_state_nx = S_IDLE;
      w_err      = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_kv) begin
          if (w_dig) begin
            w_wr_en    = 1'b1;
            w_wr_addr  = A_ADDR;
            w_wr_data  = w_key;
            w_state_nx = S_GOT_A;
          end else begin
            w_err = 1'b1;
          end
        end
        S_GOT_A: if (w_kv) begin
          unique case (1'b1)
            w_dig: begin
              w_wr_en   = 1'b1;
              w_wr_addr = A_ADDR;
              w_wr_data = w_key;
            end
            w_op: begin
              w_alu_op   = key_to_op(w_key);
              w_state_nx = S_WAIT_B;
            end
            default: w_err = 1'b1;
          endcase
        end
        S_WAIT_B: if (w_kv) begin
          if (w_dig) begin
            w_wr_en    = 1'b1;
            w_wr_addr  = B_ADDR;
            w_wr_data  = w_key;
            w_state_nx = S_GOT_B;
          end else begin
            w_err = 1'b1;
          end
        end
        S_GOT_B: if (w_kv) begin
          unique case (1'b1)
            w_dig: begin
              w_wr_en   = 1'b1;
              w_wr_addr = B_ADDR;
              w_wr_data = w_key;
            end
            w_op:  w_alu_op   = key_to_op(w_key);
            w_ent: w_state_nx = S_EXEC;
            default: w_err = 1'b1;
          endcase
        end
        S_EXEC: begin
          w_rd_a     = A_ADDR;
          w_rd_b     = B_ADDR;
          w_err      = w_kv;
          w_state_nx = S_CAPT;
        end
        // first CAPT cycle lets the ALU settle on
        // the held addresses, the second captures
        S_CAPT: begin
          w_err = w_kv;
          if (r_settle) begin
            w_result   = bus.alu_result;
            w_zero     = bus.alu_zero;
            w_rv       = 1'b1;
            w_chain    = 1'b0;
            w_state_nx = S_SHOW;
          end else begin
            w_settle = 1'b1;
          end
        end
        S_SHOW: if (w_kv) begin
          unique case (1'b1)
            w_dig: begin
              w_wr_en    = 1'b1;
              w_wr_addr  = A_ADDR;
              w_wr_data  = w_key;
              w_chain    = 1'b0;
              w_state_nx = S_GOT_A;
            end
            w_op: begin
`ifdef CALC_SEQ_CHAIN_EN
              w_alu_op   = key_to_op(w_key);
              w_chain    = 1'b1;
              w_state_nx = S_WAIT_B;
`else
              w_err = 1'b1;
`endif
            end
            default: ;
          endcase
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 2'd0;
      r_wr_data <= 4'd0;
      r_rd_a    <= A_ADDR;
      r_rd_b    <= B_ADDR;
      r_alu_op  <= OP_ADD;
      r_chain   <= 1'b0;
      r_result  <= 8'h00;
      r_zero    <= 1'b0;
      r_rv      <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_settle  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_rd_a    <= w_rd_a;
      r_rd_b    <= w_rd_b;
      r_alu_op  <= w_alu_op;
      r_chain   <= w_chain;
      r_result  <= w_result;
      r_zero    <= w_zero;
      r_rv      <= w_rv;
      r_err     <= w_err;
      r_busy    <= (w_state_nx == S_EXEC) ||
                   (w_state_nx == S_CAPT);
      r_settle  <= w_settle;
    end
  end

  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.rd_addr_a    = r_rd_a;
  assign bus.rd_addr_b    = r_rd_b;
  assign bus.alu_op       = r_alu_op;
  assign bus.chain_sel    = r_chain;
  assign bus.result_q     = r_result;
  assign bus.zero_q       = r_zero;
  assign bus.result_valid = r_rv;
  assign bus.err          = r_err;
  assign bus.busy         = r_busy;
  assign bus.state_o      = r_state;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a small
// register bank and ALU model around it.
module tb_calc_sequencer;
  import calc_seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_tot = 0;

  calc_seq_if bus();

  calc_sequencer #(
    .TIMEOUT_CYCLES(24'd16),
    .A_ADDR(2'd0),
    .B_ADDR(2'd1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] bank [4];
  logic [7:0] m_a, m_b, m_r;

  always @(posedge clk)
    if (bus.wr_en) bank[bus.wr_addr] <= bus.wr_data;

  always_comb begin
    m_a = bus.chain_sel ? bus.result_q :
          {4'h0, bank[bus.rd_addr_a]};
    m_b = {4'h0, bank[bus.rd_addr_b]};
    m_r = 8'h00;
    case (bus.alu_op)
      2'd0: m_r = m_a + m_b;
      2'd1: m_r = m_a - m_b;
      2'd2: m_r = m_a & m_b;
      default: m_r = m_a | m_b;
    endcase
    bus.alu_result = m_r;
    bus.alu_zero   = (m_r == 8'h00);
  end

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    reset = 1'b1;
    tick(2);
    n_tot++;
    if (bus.state_o !== 3'd0)
      $display("FAIL rst_state got %0d want 0",
               bus.state_o);
    else n_pass++;
    n_tot++;
    if (bus.rd_addr_a !== 2'd0 ||
        bus.rd_addr_b !== 2'd1)
      $display("FAIL rst_rd got %0d/%0d want 0/1",
               bus.rd_addr_a, bus.rd_addr_b);
    else n_pass++;
    n_tot++;
    if ({bus.wr_en, bus.err, bus.busy,
         bus.result_valid, bus.chain_sel,
         bus.zero_q} !== 6'b0 ||
        bus.result_q !== 8'h00 ||
        bus.alu_op !== 2'd0)
      $display("FAIL rst_outs got %b_%0h want 0",
               {bus.wr_en, bus.err, bus.busy,
                bus.result_valid, bus.chain_sel,
                bus.zero_q}, bus.result_q);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add;
    press(4'h3);
    n_tot++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !==
        {1'b1, 2'd0, 4'd3})
      $display("FAIL add_wrA got %b want 1_00_0011",
               {bus.wr_en, bus.wr_addr, bus.wr_data});
    else n_pass++;
    press(KEY_ADD);
    n_tot++;
    if (bus.state_o !== 3'd2 || bus.alu_op !== 2'd0
        || bus.wr_en !== 1'b0)
      $display("FAIL add_op got st%0d op%0d want 2/0",
               bus.state_o, bus.alu_op);
    else n_pass++;
    press(4'h5);
    n_tot++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data} !==
        {1'b1, 2'd1, 4'd5})
      $display("FAIL add_wrB got %b want 1_01_0101",
               {bus.wr_en, bus.wr_addr, bus.wr_data});
    else n_pass++;
    press(KEY_ENTER);
    tick(2);
    n_tot++;
    if (bus.result_valid !== 1'b0 ||
        bus.busy !== 1'b1)
      $display("FAIL add_early got rv%b busy%b want 0/1",
               bus.result_valid, bus.busy);
    else n_pass++;
    tick(1);
    n_tot++;
    if (bus.result_valid !== 1'b1 ||
        bus.result_q !== 8'd8 ||
        bus.rd_addr_a !== 2'd0 ||
        bus.rd_addr_b !== 2'd1)
      $display("FAIL add_res got rv%b r%0d want 1/8",
               bus.result_valid, bus.result_q);
    else n_pass++;
    n_tot++;
    if (bus.wr_en !== 1'b0 || bus.state_o !== 3'd6)
      $display("FAIL add_show got wr%b st%0d want 0/6",
               bus.wr_en, bus.state_o);
    else n_pass++;
    tick(1);
    n_tot++;
    if (bus.result_valid !== 1'b0 ||
        bus.result_q !== 8'd8)
      $display("FAIL add_hold got rv%b r%0d want 0/8",
               bus.result_valid, bus.result_q);
    else n_pass++;
  endtask

  task automatic test_rewrite;
    logic [3:0] keys [8];
    logic [2:0] exp_st [8];
    keys = '{4'h7, 4'h2, KEY_SUB, 4'h9, 4'h4,
             KEY_ENTER, 4'h0, 4'h0};
    exp_st = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3,
               3'd4, 3'd5, 3'd5};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) press(keys[i]);
      else tick(1);
      n_tot++;
      if (bus.state_o !== exp_st[i])
        $display("FAIL rw_state%0d got %0d want %0d",
                 i, bus.state_o, exp_st[i]);
      else n_pass++;
    end
    tick(1);
    n_tot++;
    if (bus.state_o !== 3'd6 ||
        bus.result_q !== 8'hFE ||
        bus.alu_op !== 2'd1 ||
        bus.zero_q !== 1'b0)
      $display("FAIL rw_res got st%0d r%0h op%0d want 6/fe/1",
               bus.state_o, bus.result_q, bus.alu_op);
    else n_pass++;
  endtask

  task automatic test_errors;
    press(KEY_CLEAR);
    n_tot++;
    if (bus.state_o !== 3'd0 ||
        bus.result_q !== 8'h00)
      $display("FAIL er_clr got st%0d r%0h want 0/0",
               bus.state_o, bus.result_q);
    else n_pass++;
    press(KEY_ENTER);
    n_tot++;
    if (bus.err !== 1'b1 || bus.state_o !== 3'd0)
      $display("FAIL er_idle got e%b st%0d want 1/0",
               bus.err, bus.state_o);
    else n_pass++;
    tick(1);
    n_tot++;
    if (bus.err !== 1'b0)
      $display("FAIL er_pulse got %b want 0", bus.err);
    else n_pass++;
    press(4'h1);
    press(KEY_ADD);
    press(KEY_ADD);
    n_tot++;
    if (bus.err !== 1'b1 || bus.state_o !== 3'd2)
      $display("FAIL er_waitb got e%b st%0d want 1/2",
               bus.err, bus.state_o);
    else n_pass++;
    press(4'h1);
    press(KEY_ENTER);
    press(4'h3);
    n_tot++;
    if (bus.err !== 1'b1 || bus.state_o !== 3'd5 ||
        bus.wr_en !== 1'b0)
      $display("FAIL er_exec got e%b st%0d want 1/5",
               bus.err, bus.state_o);
    else n_pass++;
    press(4'h4);
    n_tot++;
    if (bus.err !== 1'b1 || bus.state_o !== 3'd5)
      $display("FAIL er_capt got e%b st%0d want 1/5",
               bus.err, bus.state_o);
    else n_pass++;
    tick(1);
    n_tot++;
    if (bus.state_o !== 3'd6 ||
        bus.result_valid !== 1'b1 ||
        bus.result_q !== 8'd2 || bus.err !== 1'b0)
      $display("FAIL er_done got st%0d rv%b r%0d want 6/1/2",
               bus.state_o, bus.result_valid,
               bus.result_q);
    else n_pass++;
  endtask

  task automatic test_timeout;
    press(4'h5);
    tick(15);
    n_tot++;
    if (bus.state_o !== 3'd1 || bus.err !== 1'b0)
      $display("FAIL to_before got st%0d e%b want 1/0",
               bus.state_o, bus.err);
    else n_pass++;
    tick(1);
    n_tot++;
    if (bus.state_o !== 3'd0 || bus.err !== 1'b1)
      $display("FAIL to_fire got st%0d e%b want 0/1",
               bus.state_o, bus.err);
    else n_pass++;
    press(4'h5);
    tick(14);
    press(4'h6);
    tick(15);
    n_tot++;
    if (bus.state_o !== 3'd1 || bus.err !== 1'b0)
      $display("FAIL to_rearm got st%0d e%b want 1/0",
               bus.state_o, bus.err);
    else n_pass++;
    tick(1);
    n_tot++;
    if (bus.state_o !== 3'd0 || bus.err !== 1'b1)
      $display("FAIL to_fire2 got st%0d e%b want 0/1",
               bus.state_o, bus.err);
    else n_pass++;
  endtask

  task automatic test_clear_reset;
    press(4'h3);
    press(KEY_ADD);
    press(4'h4);
    press(KEY_ENTER);
    tick(3);
    n_tot++;
    if (bus.result_q !== 8'd7)
      $display("FAIL cr_res got %0d want 7",
               bus.result_q);
    else n_pass++;
    press(4'h2);
    press(KEY_ADD);
    press(4'h1);
    press(KEY_CLEAR);
    n_tot++;
    if (bus.state_o !== 3'd0 ||
        bus.result_q !== 8'h00)
      $display("FAIL cr_gotb got st%0d r%0d want 0/0",
               bus.state_o, bus.result_q);
    else n_pass++;
    press(4'h3);
    press(KEY_ADD);
    press(4'h4);
    press(KEY_ENTER);
    tick(3);
    @(negedge clk);
    reset = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code = KEY_CLEAR;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    n_tot++;
    if (bus.state_o !== 3'd0 ||
        bus.result_q !== 8'h00 || bus.err !== 1'b0)
      $display("FAIL cr_rstclr got st%0d r%0d e%b want 0",
               bus.state_o, bus.result_q, bus.err);
    else n_pass++;
    press(4'h6);
    press(KEY_SUB);
    press(4'h2);
    press(KEY_ENTER);
    n_tot++;
    if (bus.state_o !== 3'd4 || bus.alu_op !== 2'd1)
      $display("FAIL cr_exec got st%0d op%0d want 4/1",
               bus.state_o, bus.alu_op);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_tot++;
    if (bus.state_o !== 3'd0 || bus.alu_op !== 2'd0 ||
        bus.busy !== 1'b0 || bus.wr_en !== 1'b0 ||
        bus.rd_addr_a !== 2'd0 ||
        bus.rd_addr_b !== 2'd1)
      $display("FAIL cr_rstx got st%0d op%0d busy%b want 0/0/0",
               bus.state_o, bus.alu_op, bus.busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_chain;
    press(4'h3);
    press(KEY_ADD);
    press(4'h5);
    press(KEY_ENTER);
    tick(3);
    press(KEY_OR);
`ifdef CALC_SEQ_CHAIN_EN
    n_tot++;
    if (bus.state_o !== 3'd2 ||
        bus.chain_sel !== 1'b1 ||
        bus.alu_op !== 2'd3)
      $display("FAIL ch_op got st%0d c%b op%0d want 2/1/3",
               bus.state_o, bus.chain_sel, bus.alu_op);
    else n_pass++;
    press(4'h1);
    press(KEY_ENTER);
    tick(2);
    n_tot++;
    if (bus.chain_sel !== 1'b1 || bus.busy !== 1'b1)
      $display("FAIL ch_exec got c%b busy%b want 1/1",
               bus.chain_sel, bus.busy);
    else n_pass++;
    tick(1);
    n_tot++;
    if (bus.result_valid !== 1'b1 ||
        bus.result_q !== 8'd9 ||
        bus.chain_sel !== 1'b0)
      $display("FAIL ch_res got rv%b r%0d c%b want 1/9/0",
               bus.result_valid, bus.result_q,
               bus.chain_sel);
    else n_pass++;
`else
    n_tot++;
    if (bus.err !== 1'b1 || bus.state_o !== 3'd6 ||
        bus.chain_sel !== 1'b0)
      $display("FAIL ch_off got e%b st%0d c%b want 1/6/0",
               bus.err, bus.state_o, bus.chain_sel);
    else n_pass++;
    n_tot++;
    if (bus.result_q !== 8'd8 || bus.alu_op !== 2'd0)
      $display("FAIL ch_hold got r%0d op%0d want 8/0",
               bus.result_q, bus.alu_op);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_rewrite();
    test_errors();
    test_timeout();
    test_clear_reset();
    test_chain();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
